// File: rtl/pipe_stage_fifo.sv
// pipe_stage_fifo: DEPTH-entry valid/ready buffer between core stages, with flush and occupancy count.
// Define PIPE_STAGE_BYPASS_EN for a zero-latency pass-through of upstream data while the buffer is empty.
module pipe_stage_fifo #(
  parameter int unsigned      WIDTH     = 96,
  parameter int unsigned      DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned    AW       = $clog2(DEPTH);
  localparam int unsigned    CW       = AW + 1;
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
  localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             empty, full, bypass, push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign s_ready = ~full;
  assign count   = count_q;

`ifdef PIPE_STAGE_BYPASS_EN
  // Flush squashes the pass-through so a redirected instruction never leaks downstream.
  assign bypass  = empty & s_valid & ~flush;
  assign m_valid = ~empty | bypass;
  assign m_data  = bypass ? s_data : mem_q[rdPtr_q];
`else
  assign bypass  = 1'b0;
  assign m_valid = ~empty;
  assign m_data  = mem_q[rdPtr_q];
`endif

  // A bypassed transfer that is consumed immediately never touches storage.
  assign push = s_valid & s_ready & ~flush & ~(bypass & m_ready);
  assign pop  = ~empty & m_ready & ~flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PTR_ONE;
      if (pop)  rdPtr_d = rdPtr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      if (push) mem_q[wrPtr_q] <= s_data;
    end
  end

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// tb_pipe_stage_fifo: directed vector table on a DEPTH=2 instance plus a randomised
// scoreboard stream on a DEPTH=4 instance; follows PIPE_STAGE_BYPASS_EN if defined.
module tb_pipe_stage_fifo;

`ifdef PIPE_STAGE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [7:0] RV = 8'hA5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       sValid2, sReady2, mValid2, mReady2, flush2;
  logic [7:0] sData2, mData2;
  logic [1:0] count2;

  logic       sValid4, sReady4, mValid4, mReady4, flush4;
  logic [7:0] sData4, mData4;
  logic [2:0] count4;

  pipe_stage_fifo #(.WIDTH(8), .DEPTH(2), .RESET_VAL(RV)) dut2 (
    .clk(clk), .rst(rst),
    .s_valid(sValid2), .s_ready(sReady2), .s_data(sData2),
    .m_valid(mValid2), .m_ready(mReady2), .m_data(mData2),
    .flush(flush2), .count(count2)
  );

  pipe_stage_fifo #(.WIDTH(8), .DEPTH(4), .RESET_VAL(RV)) dut4 (
    .clk(clk), .rst(rst),
    .s_valid(sValid4), .s_ready(sReady4), .s_data(sData4),
    .m_valid(mValid4), .m_ready(mReady4), .m_data(mData4),
    .flush(flush4), .count(count4)
  );

  typedef struct {
    logic       sValid;
    logic [7:0] sData;
    logic       mReady;
    logic       flush;
    logic       expSReady;
    logic       expMValid;
    logic [7:0] expMData;
    logic [1:0] expCount;
  } vec_t;

  vec_t vecs[$];
  int   testsRun  = 0;
  int   failCount = 0;

  task automatic addRow(input logic sv, input logic [7:0] sd, input logic mr, input logic fl,
                        input logic er, input logic ev, input logic [7:0] ed, input logic [1:0] ec);
    vec_t v;
    v.sValid = sv; v.sData = sd; v.mReady = mr; v.flush = fl;
    v.expSReady = er; v.expMValid = ev; v.expMData = ed; v.expCount = ec;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int idx, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s[%0d]: got 0x%0h, expected 0x%0h", name, idx, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sValid2 = v.sValid;
    sData2  = v.sData;
    mReady2 = v.mReady;
    flush2  = v.flush;
  endtask

  initial begin
    logic [7:0] model[$];
    logic [7:0] nextData, expData;
    logic       pending, expSReady, expMValid, byp, push, pop;
    int         transfers, cycles;

    sValid2 = 0; sData2 = 0; mReady2 = 0; flush2 = 0;
    sValid4 = 0; sData4 = 0; mReady4 = 0; flush4 = 0;

    // Rows: inputs for one cycle, then outputs expected just before that cycle's edge.
    addRow(1, 8'h11, 0, 0, 1, BYP, BYP ? 8'h11 : RV,    0);
    addRow(1, 8'h22, 0, 0, 1, 1,   8'h11,               1);
    addRow(1, 8'h33, 0, 0, 0, 1,   8'h11,               2);
    addRow(1, 8'h33, 0, 0, 0, 1,   8'h11,               2);
    addRow(1, 8'h33, 1, 0, 0, 1,   8'h11,               2);
    addRow(1, 8'h33, 1, 0, 1, 1,   8'h22,               1);
    addRow(0, 8'h00, 1, 0, 1, 1,   8'h33,               1);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'h22,               0);
    addRow(1, 8'h66, 0, 0, 1, BYP, BYP ? 8'h66 : 8'h22, 0);
    addRow(1, 8'h77, 0, 0, 1, 1,   8'h66,               1);
    addRow(1, 8'h44, 1, 1, 0, 1,   8'h66,               2);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'h77,               0);
    addRow(1, 8'h88, 0, 0, 1, BYP, BYP ? 8'h88 : 8'h77, 0);
    addRow(1, 8'h99, 1, 1, 1, 1,   8'h88,               1);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'h88,               0);
    addRow(1, 8'hAA, 0, 0, 1, BYP, BYP ? 8'hAA : 8'h88, 0);
    addRow(0, 8'h00, 1, 0, 1, 1,   8'hAA,               1);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'h66,               0);
    addRow(1, 8'hBB, 1, 1, 1, 0,   8'h66,               0);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'hAA,               0);
`ifdef PIPE_STAGE_BYPASS_EN
    addRow(1, 8'h55, 1, 0, 1, 1,   8'h55,               0);
    addRow(0, 8'h00, 0, 0, 1, 0,   8'hAA,               0);
    addRow(1, 8'h55, 0, 0, 1, 1,   8'h55,               0);
    addRow(0, 8'h00, 0, 0, 1, 1,   8'h55,               1);
`endif

    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    checkOutput("rstSReady", 0, 32'(sReady2), 1);
    checkOutput("rstMValid", 0, 32'(mValid2), 0);
    checkOutput("rstCount",  0, 32'(count2),  0);
    checkOutput("rstMData",  0, 32'(mData2),  32'(RV));
    checkOutput("rstCount4", 0, 32'(count4),  0);
    checkOutput("rstMData4", 0, 32'(mData4),  32'(RV));

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput("sReady", i, 32'(sReady2), 32'(vecs[i].expSReady));
      checkOutput("mValid", i, 32'(mValid2), 32'(vecs[i].expMValid));
      checkOutput("mData",  i, 32'(mData2),  32'(vecs[i].expMData));
      checkOutput("count",  i, 32'(count2),  32'(vecs[i].expCount));
    end
    @(posedge clk);
    #1 sValid2 = 0; mReady2 = 0; flush2 = 0;

    // Stream on the DEPTH=4 instance; a refused offer is held until accepted.
    nextData  = 8'h00;
    pending   = 0;
    transfers = 0;
    cycles    = 0;
    while (transfers < 1000 && cycles < 20000) begin
      @(posedge clk);
      #1;
      if (!pending) begin
        sValid4 = ($urandom_range(0, 3) != 0);
        sData4  = nextData;
      end
      mReady4 = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      expSReady = (model.size() != 4);
      byp       = BYP && (model.size() == 0) && sValid4;
      expMValid = (model.size() != 0) || byp;
      push      = sValid4 && expSReady;
      pop       = expMValid && mReady4;
      checkOutput("streamSReady", cycles, 32'(sReady4), 32'(expSReady));
      checkOutput("streamMValid", cycles, 32'(mValid4), 32'(expMValid));
      checkOutput("streamCount",  cycles, 32'(count4),  32'(model.size()));
      if (pop) begin
        expData = byp ? sData4 : model[0];
        checkOutput("streamData", transfers, 32'(mData4), 32'(expData));
        transfers++;
      end
      if (!(byp && pop)) begin
        if (pop)  void'(model.pop_front());
        if (push) model.push_back(sData4);
      end
      if (push) nextData = nextData + 8'h01;
      pending = sValid4 && !push;
      cycles++;
    end
    checkOutput("streamTransfers", 0, 32'(transfers), 1000);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
